// File: rtl/reg_block_wr_arbiter.sv
// reg_block_wr_arbiter: round-robin owner of the register block's single write
// port. After reset it zero-fills every entry, then forwards one requester's
// write per cycle on registered Addr_In/Data_In.
module reg_block_wr_arbiter #(
  parameter int unsigned NUM_REQ           = 3,
  parameter int unsigned IN_ADDR_WIDTH     = 9,
  parameter int unsigned ACTUAL_ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH        = 16,
  parameter logic [IN_ADDR_WIDTH-1:0] IDLE_ADDR = '1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*IN_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              ack,
  output logic [IN_ADDR_WIDTH-1:0]        Addr_In,
  output logic [DATA_WIDTH-1:0]           Data_In,
  output logic                            init_done
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned DEPTH = 1 << ACTUAL_ADDR_WIDTH;
  localparam logic [ACTUAL_ADDR_WIDTH-1:0] LAST_ENTRY = ACTUAL_ADDR_WIDTH'(DEPTH - 1);
  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_t;

  state_t                       state;
  logic [ACTUAL_ADDR_WIDTH-1:0] fill_cnt;
  logic [PTR_W-1:0]             last;

  logic                         grant_valid;
  logic [PTR_W-1:0]             grant_idx;
  logic [PTR_W-1:0]             cand;

  // Round-robin search starting just after the last winner; no grant in INIT or reset.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (state == ST_ARB && !rst) begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        cand = PTR_W'((32'(last) + k) % NUM_REQ);
        if (!grant_valid && req[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  // One-hot grant decode of the search result.
  always_comb begin
    ack = '0;
    if (grant_valid) begin
      ack = NUM_REQ'(1) << grant_idx;
    end
  end

  // Fill/arbitration sequencer; bus outputs and pointer are all registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      fill_cnt  <= '0;
      last      <= LAST_REQ;
      Addr_In   <= IDLE_ADDR;
      Data_In   <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          Addr_In  <= IN_ADDR_WIDTH'(fill_cnt);
          Data_In  <= '0;
          fill_cnt <= fill_cnt + ACTUAL_ADDR_WIDTH'(1);
          if (fill_cnt == LAST_ENTRY) begin
            state     <= ST_ARB;
            init_done <= 1'b1;
          end
        end
        ST_ARB: begin
          if (grant_valid) begin
            Addr_In <= req_addr[32'(grant_idx) * IN_ADDR_WIDTH +: IN_ADDR_WIDTH];
            Data_In <= req_data[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
            last    <= grant_idx;
          end else begin
            Addr_In <= IDLE_ADDR;
            Data_In <= '0;
          end
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

  // Grant is never more than one requester.
  a_ack_onehot: assert property (@(posedge clk) $onehot0(ack));

  // No grants while the fill is still running.
  a_no_ack_init: assert property (@(posedge clk) disable iff (rst)
    (state == ST_INIT) |-> (ack == '0));

  // A requester that is waiting for its grant must keep requesting.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_hold_chk
    a_req_hold: assert property (@(posedge clk) disable iff (rst)
      (state == ST_ARB && req[gi] && !ack[gi]) |=> req[gi]);
  end

endmodule

// File: tb/tb_reg_block_wr_arbiter.sv
// Directed bench for reg_block_wr_arbiter with a behavioural register block.
module tb_reg_block_wr_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = 9;
  localparam int unsigned DW = 16;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     ack;
  logic [AW-1:0]     Addr_In;
  logic [DW-1:0]     Data_In;
  logic              init_done;

  int n_assert = 0;
  int n_fail   = 0;

  logic          mem_preset;
  logic [DW-1:0] mem     [32];
  logic [DW-1:0] exp_mem [32];
  logic [2:0]    rr_exp  [6];

  reg_block_wr_arbiter #(
    .NUM_REQ(3), .IN_ADDR_WIDTH(9), .ACTUAL_ADDR_WIDTH(5), .DATA_WIDTH(16), .IDLE_ADDR(9'h1FF)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack), .Addr_In(Addr_In), .Data_In(Data_In), .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register block write side: commits only when upper address bits are zero.
  always @(posedge clk) begin
    if (mem_preset) begin
      for (int k = 0; k < 32; k++) mem[k] <= 16'hDEAD;
    end else if (Addr_In[8:5] == 4'd0) begin
      mem[Addr_In[4:0]] <= Data_In;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[idx*AW +: AW] = a;
    req_data[idx*DW +: DW] = d;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_addr = '0; req_data = '0; mem_preset = 1'b1;
    for (int k = 0; k < 32; k++) exp_mem[k] = '0;
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100;
    rr_exp[3] = 3'b001; rr_exp[4] = 3'b010; rr_exp[5] = 3'b100;

    // Reset held 3 cycles
    repeat (3) tick();
    chk("rst_addr", 32'(Addr_In), 'h1FF);
    chk("rst_data", 32'(Data_In), 'h0);
    chk("rst_done", 32'(init_done), 'h0);
    chk("rst_ack", 32'(ack), 'h0);

    // Fill with all requesters pending at out-of-range addresses
    mem_preset = 1'b0;
    set_req(0, 9'h100, 16'hA000);
    set_req(1, 9'h101, 16'hA001);
    set_req(2, 9'h102, 16'hA002);
    req = 3'b111;
    rst = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      tick();
      chk("fill_addr", 32'(Addr_In), 32'(e - 1));
      chk("fill_data", 32'(Data_In), 'h0);
      chk("fill_done", 32'(init_done), (e == 32) ? 'h1 : 'h0);
      if (e < 32) chk("fill_ack", 32'(ack), 'h0);
    end
    chk("post_fill_ack0", 32'(ack), 'b001);
    tick();
    chk("post_fill_bus0", 32'(Addr_In), 'h100);
    chk("post_fill_dat0", 32'(Data_In), 'hA000);
    req = 3'b110; #1;
    chk("post_fill_ack1", 32'(ack), 'b010);
    tick();
    chk("post_fill_bus1", 32'(Addr_In), 'h101);
    req = 3'b100; #1;
    chk("post_fill_ack2", 32'(ack), 'b100);
    tick();
    chk("post_fill_bus2", 32'(Addr_In), 'h102);
    req = 3'b000; #1;
    chk("post_fill_ack_idle", 32'(ack), 'h0);
    tick();
    chk("idle_addr", 32'(Addr_In), 'h1FF);
    chk("idle_data", 32'(Data_In), 'h0);
    for (int k = 0; k < 32; k++) chk("fill_mem", 32'(mem[k]), 'h0);

    // Round-robin with all requesters held (last = 2)
    set_req(0, 9'h120, 16'hC000);
    set_req(1, 9'h121, 16'hC001);
    set_req(2, 9'h122, 16'hC002);
    req = 3'b111; #1;
    for (int c = 0; c < 6; c++) begin
      chk("rr_ack", 32'(ack), 32'(rr_exp[c]));
      tick();
      chk("rr_bus", 32'(Addr_In), 'h120 + 32'(c % 3));
    end
    req = 3'b011; #1;
    chk("rr_drain_ack0", 32'(ack), 'b001);
    tick();
    req = 3'b010; #1;
    chk("rr_drain_ack1", 32'(ack), 'b010);
    tick();
    req = 3'b001; #1;
    chk("rr_last0_ack", 32'(ack), 'b001);
    tick();
    req = 3'b101; #1;
    chk("rr_101_ack", 32'(ack), 'b100);
    tick();
    chk("rr_101_bus", 32'(Addr_In), 'h122);
    req = 3'b001; #1;
    chk("rr_101_ack0", 32'(ack), 'b001);
    tick();
    req = 3'b000;

    // Single requester 1
    set_req(1, 9'h005, 16'hBEEF);
    req = 3'b010; #1;
    chk("single_ack", 32'(ack), 'b010);
    tick();
    chk("single_addr", 32'(Addr_In), 'h005);
    chk("single_data", 32'(Data_In), 'hBEEF);
    req = 3'b000; #1;
    chk("single_ack_off", 32'(ack), 'h0);
    tick();
    chk("single_idle", 32'(Addr_In), 'h1FF);
    chk("single_mem5", 32'(mem[5]), 'hBEEF);
    exp_mem[5] = 16'hBEEF;

    // Back-to-back writes from requester 0
    req = 3'b001;
    for (int k = 0; k < 4; k++) begin
      set_req(0, AW'(k), DW'(16'h1111 * (k + 1)));
      #1;
      chk("b2b_ack", 32'(ack), 'b001);
      tick();
      chk("b2b_addr", 32'(Addr_In), 32'(k));
      chk("b2b_data", 32'(Data_In), 32'(16'h1111 * (k + 1)));
      exp_mem[k] = DW'(16'h1111 * (k + 1));
    end
    req = 3'b000;
    tick();
    chk("b2b_idle", 32'(Addr_In), 'h1FF);
    for (int k = 0; k < 4; k++) chk("b2b_mem", 32'(mem[k]), 32'(exp_mem[k]));

    // Out-of-range address is granted and forwarded, no entry changes
    set_req(2, 9'h040, 16'hFFFF);
    req = 3'b100; #1;
    chk("oor_ack", 32'(ack), 'b100);
    tick();
    chk("oor_addr", 32'(Addr_In), 'h040);
    chk("oor_data", 32'(Data_In), 'hFFFF);
    req = 3'b000;
    tick();
    tick();
    for (int k = 0; k < 32; k++) chk("oor_mem", 32'(mem[k]), 32'(exp_mem[k]));

    // Reset during arbitration with all requesters pending
    set_req(0, 9'h120, 16'hC000);
    set_req(1, 9'h121, 16'hC001);
    set_req(2, 9'h122, 16'hC002);
    req = 3'b111; #1;
    chk("mid_pre_ack", 32'(ack), 'b001);
    tick();
    rst = 1'b1; #1;
    chk("mid_rst_ack", 32'(ack), 'h0);
    tick();
    chk("mid_rst_addr", 32'(Addr_In), 'h1FF);
    chk("mid_rst_done", 32'(init_done), 'h0);
    chk("mid_rst_ack2", 32'(ack), 'h0);
    rst = 1'b0;
    tick();
    chk("refill_addr0", 32'(Addr_In), 'h0);
    chk("refill_done0", 32'(init_done), 'h0);
    chk("refill_ack0", 32'(ack), 'h0);
    repeat (31) tick();
    chk("refill_addr31", 32'(Addr_In), 'h1F);
    chk("refill_done", 32'(init_done), 'h1);
    chk("refill_first_ack", 32'(ack), 'b001);
    tick();
    chk("refill_first_bus", 32'(Addr_In), 'h120);
    req = 3'b110; #1;
    chk("refill_ack1", 32'(ack), 'b010);
    tick();
    req = 3'b100; #1;
    chk("refill_ack2", 32'(ack), 'b100);
    tick();
    req = 3'b000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_block_wr_arbiter.md
# reg_block_wr_arbiter

Write-port controller for the 32-entry register block. It arbitrates the block's single write port among `NUM_REQ` requesters using round-robin, and drives the block's `Addr_In`/`Data_In` from registers. After reset it sequences a zero-fill of all entries, because the register block itself has no reset. It sits directly in front of the register block's write side; the read side is not touched.

## Interface
- `NUM_REQ`, 3: number of requesters (2..8).
- `IN_ADDR_WIDTH`, 9: write-address width presented to the register block.
- `ACTUAL_ADDR_WIDTH`, 5: implemented address bits; depth = 1<<ACTUAL_ADDR_WIDTH = 32.
- `DATA_WIDTH`, 16: data width.
- `IDLE_ADDR`, all ones (9'h1FF): parked address. Its upper bits are nonzero, so the block performs no write.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in NUM_REQ: per-requester write request, level.
- `req_addr` in NUM_REQ*IN_ADDR_WIDTH: flattened addresses; requester i occupies bits [i*IN_ADDR_WIDTH +: IN_ADDR_WIDTH].
- `req_data` in NUM_REQ*DATA_WIDTH: flattened data, packed the same way.
- `ack` out NUM_REQ: one-hot or zero grant, combinational.
- `Addr_In` out IN_ADDR_WIDTH: registered; connects to the register block.
- `Data_In` out DATA_WIDTH: registered; connects to the register block.
- `init_done` out 1: registered; high once the zero-fill is complete.

## Operation
- **States.** INIT (zero-fill) and ARB (arbitration). `rst` forces state=INIT, fill counter=0, and round-robin pointer `last`=NUM_REQ-1.
- **Reset values.** `Addr_In`=IDLE_ADDR, `Data_In`=0, `init_done`=0, `ack`=0.
- **INIT.**
  - Each clock: `Addr_In`<=counter, `Data_In`<=0, counter+1.
  - When counter==31, the same edge sets state<=ARB and `init_done`<=1.
  - `ack`=0 throughout INIT, regardless of `req`.
- **ARB, ack generation.** `ack` is combinational from `req`, `last` and state. The first requester with `req` high is granted, searching from (`last`+1) mod NUM_REQ upward with wrap-around.
- **ARB, on a clock edge with a grant to i:**
  - `Addr_In`<=req_addr[i] and `Data_In`<=req_data[i].
  - `last`<=i.
- **ARB, on a clock edge with no request:**
  - `Addr_In`<=IDLE_ADDR and `Data_In`<=0.
  - `last` is unchanged.
- **Handshake.**
  - A transfer occurs on a rising edge where `req[i]`&`ack[i]`.
  - The requester holds `req`, addr and data stable until that edge.
  - It may present a new request in the next cycle, which allows back-to-back transfers.
  - `ack` may fall without a transfer only if `req` falls. Requesters must not withdraw while un-acked; this is checked by an assertion.
- **Out-of-range addresses.** Addresses with nonzero upper bits are granted and forwarded unchanged. The register block ignores them; no error is flagged.
- **Fairness.** With all requesters held high, grants rotate 0,1,2,0,… Any requester waits at most NUM_REQ-1 grants.

## Timing
- Grant-to-bus latency is 1 cycle: `Addr_In`/`Data_In` carry the granted write in the cycle after `ack`.
- The register block commits the write on the following edge, so an ack at edge t is written at edge t+2.
- Exactly one write reaches the block per cycle. INIT and ARB writes never overlap.
- Zero-fill timing, counting edges after `rst` deasserts:
  - Edges 1..32 present addresses 0..31.
  - `init_done`=1 from edge 32.
  - The first `ack` is possible in the cycle after edge 32.
  - The first arbitrated write appears on the bus at edge 33.
- Reset mid-INIT or mid-ARB takes effect at the next edge:
  - The in-flight `Addr_In` is replaced by IDLE_ADDR.
  - The fill restarts from 0.
  - Pending requests are not acked until the fill completes again.
- `req` asserted while `rst` is high produces no `ack`.

## Test plan
- **Reset and fill:** hold `rst` 3 cycles, then release -> `Addr_In` steps 0..31 with `Data_In`=0 over 32 cycles; `init_done` rises at edge 32; `ack`=0 throughout even with `req`=3'b111; a read of all 32 entries returns 0.
- **Single requester:** after init, req[1] with addr 9'h005 and data 16'hBEEF -> `ack`=3'b010 that cycle; `Addr_In`=9'h005 and `Data_In`=16'hBEEF the next cycle; entry 5 reads 16'hBEEF after one more edge; `Addr_In` returns to 9'h1FF.
- **Round-robin:** `req`=3'b111 held for 6 cycles -> ack sequence 001,010,100,001,010,100; then `req`=3'b101 after last=0 -> next ack 100.
- **Back-to-back:** requester 0 issues 4 consecutive writes (addr 0..3, data 16'h1111..16'h4444) -> 4 consecutive `ack`s, no idle bus cycles, entries hold the data.
- **Out-of-range:** req[2] with addr 9'h040 and data 16'hFFFF -> acked and forwarded; every entry 0..31 is unchanged.
- **Reset mid-operation:** assert `rst` for 1 cycle during ARB with `req`=3'b111, then release -> `Addr_In`=9'h1FF, `ack`=0 and `init_done`=0; the fill restarts at address 0; the first post-fill grant goes to requester 0.
